// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM for the MIPS-subset datapath.
// Sequences PC/IR/regfile/memory enables, ALU operand muxes, ALU op and the
// sign extender's extop from the current state (Moore). Counts retired
// legal instructions.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   opcode, funct        IR[31:26], IR[5:0]
//   zero                 ALU zero flag (consumed by the datapath with pc_write_cond)
//   mem_ready            memory handshake, only with CTRL_MEM_WAIT_EN
//   pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
//   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, extop
//                        datapath controls
//   illegal_op           1-cycle pulse in DECODE for unsupported opcode/funct
//   state                current state (debug)
//   instr_cnt            retired legal instructions, wraps
//
// Optional feature macro: CTRL_MEM_WAIT_EN (memory wait states via mem_ready).
module mc_ctrl_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
`ifdef CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             extop,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_e;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpLui = 3'b101;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             mem_ok;

    // Branch resolution on zero happens in the datapath via pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = OpAdd;
        extop         = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
                if (mem_ok) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                extop     = 1'b1;
                state_d   = StFetch;
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h21, 6'h23, 6'h24, 6'h25, 6'h2A: state_d = StRExec;
                            default: illegal_op = 1'b1;
                        endcase
                    end
                    6'h23, 6'h2B:        state_d = StMemAddr;
                    6'h04:               state_d = StBranch;
                    6'h02:               state_d = StJump;
                    6'h09, 6'h0D, 6'h0F: state_d = StIExec;
                    default:             illegal_op = 1'b1;
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                extop     = 1'b1;
                state_d   = (opcode == 6'h23) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ok) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ok) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StRExec: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h23:   alu_op = OpSub;
                    6'h24:   alu_op = OpAnd;
                    6'h25:   alu_op = OpOr;
                    6'h2A:   alu_op = OpSlt;
                    default: alu_op = OpAdd;
                endcase
                state_d = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = OpSub;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    6'h0D:   alu_op = OpOr;
                    6'h0F:   alu_op = OpLui;
                    default: begin
                        alu_op = OpAdd;
                        extop  = 1'b1;
                    end
                endcase
                state_d = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Held in reset: no enable reaches the datapath, even mid-instruction.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = OpAdd;
            extop         = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode, funct;
    logic          zero;
`ifdef CTRL_MEM_WAIT_EN
    logic          mem_ready;
`endif
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a, extop, illegal_op;
    logic [1:0]    pc_source, alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic [CW-1:0] instr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .extop         (extop),
        .illegal_op    (illegal_op),
        .state         (state),
        .instr_cnt     (instr_cnt)
    );

    // {pc_write, pc_write_cond, pc_source[1:0], iord, mem_read, mem_write, ir_write,
    //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0], extop, illegal_op}
    logic [18:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, extop,
                   illegal_op};

    localparam logic [18:0] C_NONE   = 19'd0;
    localparam logic [18:0] C_FETCH  = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_DECODE = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b11, 3'b000, 1'b1, 1'b0};
    localparam logic [18:0] C_DECILL = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b11, 3'b000, 1'b1, 1'b1};
    localparam logic [18:0] C_MEMRD  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_MEMWB  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                        1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_MEMWR  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_RWB    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                        1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_BRANCH = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0};
    localparam logic [18:0] C_JUMP   = {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
    localparam logic [18:0] C_IWB    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                        1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};

    // Execute-style state: alu_src_a=1 with the given src_b, op and extop.
    function automatic logic [18:0] c_exec(logic [1:0] sb, logic [2:0] op, logic ext);
        return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sb, op, ext,
                1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check current state and controls, then advance one clock.
    task automatic cyc(input string tag, input int st, input logic [18:0] c);
        chk({tag, ":state"}, 32'(state), 32'(st));
        chk({tag, ":ctrl"}, 32'(ctrl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        chk({tag, ":back_to_fetch"}, 32'(state), 32'd0);
        chk({tag, ":cnt"}, 32'(instr_cnt), 32'(exp));
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst:state", 32'(state), 32'd0);
        chk("rst:cnt", 32'(instr_cnt), 32'd0);
        chk("rst:ctrl", 32'(ctrl), 32'(C_NONE));
        rst_n = 1'b1;
        #1;
        chk("rel:ctrl", 32'(ctrl), 32'(C_FETCH));

        // lw: 5 cycles
        opcode = 6'h23;
        cyc("lw0", 0, C_FETCH);
        cyc("lw1", 1, C_DECODE);
        cyc("lw2", 2, c_exec(2'b10, 3'b000, 1'b1));
        cyc("lw3", 3, C_MEMRD);
        cyc("lw4", 4, C_MEMWB);
        chk_cnt("lw", 1);

        // sw: 4 cycles
        opcode = 6'h2B;
        cyc("sw0", 0, C_FETCH);
        cyc("sw1", 1, C_DECODE);
        cyc("sw2", 2, c_exec(2'b10, 3'b000, 1'b1));
        cyc("sw5", 5, C_MEMWR);
        chk_cnt("sw", 2);

        // R-type ADD and SLT
        opcode = 6'h00;
        funct  = 6'h21;
        cyc("add0", 0, C_FETCH);
        cyc("add1", 1, C_DECODE);
        cyc("add6", 6, c_exec(2'b00, 3'b000, 1'b0));
        cyc("add7", 7, C_RWB);
        chk_cnt("add", 3);
        funct = 6'h2A;
        cyc("slt0", 0, C_FETCH);
        cyc("slt1", 1, C_DECODE);
        cyc("slt6", 6, c_exec(2'b00, 3'b100, 1'b0));
        cyc("slt7", 7, C_RWB);
        chk_cnt("slt", 4);

        // I-type: ori zero-extends, addiu sign-extends, lui zero-extends
        opcode = 6'h0D;
        cyc("ori0", 0, C_FETCH);
        cyc("ori1", 1, C_DECODE);
        cyc("ori10", 10, c_exec(2'b10, 3'b011, 1'b0));
        cyc("ori11", 11, C_IWB);
        chk_cnt("ori", 5);
        opcode = 6'h09;
        cyc("addiu0", 0, C_FETCH);
        cyc("addiu1", 1, C_DECODE);
        cyc("addiu10", 10, c_exec(2'b10, 3'b000, 1'b1));
        cyc("addiu11", 11, C_IWB);
        chk_cnt("addiu", 6);
        opcode = 6'h0F;
        cyc("lui0", 0, C_FETCH);
        cyc("lui1", 1, C_DECODE);
        cyc("lui10", 10, c_exec(2'b10, 3'b101, 1'b0));
        cyc("lui11", 11, C_IWB);
        chk_cnt("lui", 7);

        // beq, taken and not taken: 3 cycles either way
        opcode = 6'h04;
        zero   = 1'b1;
        cyc("beqz0", 0, C_FETCH);
        cyc("beqz1", 1, C_DECODE);
        cyc("beqz8", 8, C_BRANCH);
        chk_cnt("beqz", 8);
        zero = 1'b0;
        cyc("beqn0", 0, C_FETCH);
        cyc("beqn1", 1, C_DECODE);
        cyc("beqn8", 8, C_BRANCH);
        chk_cnt("beqn", 9);

        // j
        opcode = 6'h02;
        cyc("j0", 0, C_FETCH);
        cyc("j1", 1, C_DECODE);
        cyc("j9", 9, C_JUMP);
        chk_cnt("j", 10);

        // Illegal opcode and illegal R funct: pulse in DECODE, count unchanged
        opcode = 6'h3F;
        cyc("ill0", 0, C_FETCH);
        cyc("ill1", 1, C_DECILL);
        chk_cnt("ill", 10);
        chk("ill:pulse_gone", 32'(illegal_op), 32'd0);
        opcode = 6'h00;
        funct  = 6'h3F;
        cyc("illf0", 0, C_FETCH);
        cyc("illf1", 1, C_DECILL);
        chk_cnt("illf", 10);

        // Six more jumps take the 4-bit counter from 10 through 15 and wrap to 0
        opcode = 6'h02;
        for (int i = 0; i < 6; i++) begin
            cyc("jw0", 0, C_FETCH);
            cyc("jw1", 1, C_DECODE);
            cyc("jw9", 9, C_JUMP);
        end
        chk_cnt("wrap", 0);
        cyc("jx0", 0, C_FETCH);
        cyc("jx1", 1, C_DECODE);
        cyc("jx9", 9, C_JUMP);
        chk_cnt("postwrap", 1);

        // Reset during lw MEM_RD: strobes drop immediately, no write-back follows
        opcode = 6'h23;
        cyc("lwr0", 0, C_FETCH);
        cyc("lwr1", 1, C_DECODE);
        cyc("lwr2", 2, c_exec(2'b10, 3'b000, 1'b1));
        chk("lwr:in_memrd", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("lwr:ctrl_forced", 32'(ctrl), 32'(C_NONE));
        @(posedge clk);
        #1;
        chk_cnt("lwr", 0);
        rst_n = 1'b1;
        #1;
        cyc("lwr_after", 0, C_FETCH);
        chk("lwr:next", 32'(state), 32'd1);

`ifdef CTRL_MEM_WAIT_EN
        // Finish the pending lw, then stall in FETCH for 3 cycles
        cyc("wlw1", 1, C_DECODE);
        cyc("wlw2", 2, c_exec(2'b10, 3'b000, 1'b1));
        cyc("wlw3", 3, C_MEMRD);
        cyc("wlw4", 4, C_MEMWB);
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc("wait", 0, {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 2'b01, 3'b000, 1'b0, 1'b0});
        end
        mem_ready = 1'b1;
        #1;
        cyc("wgo", 0, C_FETCH);
        chk("wgo:state", 32'(state), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
